decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the five-stage RV64I+Zba pipeline, sitting directly downstream of fetch. It holds the IF/ID pipeline register (with stall and flush), the 32×64 integer register file written from Writeback, and the immediate generator. It presents operands, register indices and the sign-extended immediate to the ID/EX register and the hazard unit.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded on reset/flush

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- StallD  in  1  hold IF/ID contents
- FlushD  in  1  replace IF/ID contents with bubble
- PC_F  in  64  PC of instruction in Fetch
- Instr_F  in  32  raw instruction from instruction memory
- RegWrite_W  in  1  Writeback register-file write enable
- Rd_W  in  5  Writeback destination index
- Result_W  in  64  Writeback data
- PC_D  out  64  registered PC
- PCPlus4_D  out  64  PC_D + 4 (modulo 2^64)
- Instr_D  out  32  registered instruction
- Valid_D  out  1  0 when Instr_D is a reset/flush bubble
- Rs1_D, Rs2_D, Rd_D  out  5 each  Instr_D[19:15], [24:20], [11:7]
- RD1_D, RD2_D  out  64 each  register-file read data for Rs1_D, Rs2_D
- ImmExt_D  out  64  sign-extended immediate

## Operation
- IF/ID register priority per rising edge: rst > FlushD > StallD > load.
  - rst or FlushD: Instr_D←NOP_INSTR, PC_D←0, Valid_D←0.
  - StallD (no flush): all IF/ID fields hold.
  - otherwise: Instr_D←Instr_F, PC_D←PC_F, Valid_D←1.
- Register file: 32 entries × 64 bits, x0 reads 0 always and is never written.
  - Write on rising edge when RegWrite_W=1 and Rd_W≠0; rst clears all 31 writable entries to 0 (reset has priority over a same-cycle write).
  - Reads combinational. Write-through bypass: if RegWrite_W=1, Rd_W≠0 and Rd_W equals the read index, output Result_W (same-cycle WB→ID, no extra hazard stall).
- Immediate generation, selected by Instr_D[6:0], all sign-extended from Instr_D[31]:
  - I (0000011 load, 0010011 OP-IMM, 0011011 OP-IMM-32, 1100111 JALR): Instr[31:20].
  - S (0100011): {Instr[31:25], Instr[11:7]}.
  - B (1100011): {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - U (0110111 LUI, 0010111 AUIPC): {Instr[31:12], 12'b0} sign-extended to 64.
  - J (1101111): {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - All other opcodes (R-type, OP-32 incl. Zba .uw/shNadd): 0.
- Shift immediates are not specially decoded; funct6 bits pass through in ImmExt_D and Execute masks shamt.

## Timing
- Latency: Instr_F/PC_F sampled at edge n appear on Instr_D/PC_D after edge n; all other outputs are combinational from IF/ID state and register file within the same cycle.
- Reset values: Instr_D=0x00000013, PC_D=0, PCPlus4_D=4, Valid_D=0, Rs1_D=Rs2_D=Rd_D=0, RD1_D=RD2_D=0, ImmExt_D=0.
- FlushD and StallD both high: flush wins (bubble inserted).
- StallD held k cycles: outputs constant except RD1_D/RD2_D, which reflect writes/bypass during the stall.
- PC_D=0xFFFF_FFFF_FFFF_FFFC: PCPlus4_D=0 (wrap).
- rst asserted mid-operation: IF/ID and register file both cleared at that edge regardless of StallD/RegWrite_W.

## Test plan
- Reset: assert rst one cycle with RegWrite_W=1, Rd_W=5 -> Instr_D=0x00000013, Valid_D=0, PC_D=0, x5 reads 0 afterwards.
- Load/stall/flush: PC_F=0x100, Instr_F=0x00500093 -> next cycle PC_D=0x100, Rd_D=1, ImmExt_D=5, Valid_D=1; StallD=1 with new Instr_F -> PC_D stays 0x100; FlushD=1 and StallD=1 -> bubble, Valid_D=0.
- Write and bypass: write x3=0xDEAD_BEEF_0000_0001, then Instr_D=add x4,x3,x0 -> RD1_D=0xDEADBEEF00000001, RD2_D=0; same-cycle RegWrite_W to x3 with 0x7 -> RD1_D=0x7 that cycle.
- x0: RegWrite_W=1, Rd_W=0, Result_W=0xFF; read x0 -> RD1_D=0 with and without bypass window.
- Immediates: 0xFFF00093 -> 0xFFFF_FFFF_FFFF_FFFF; sw 0xFE112E23 -> −4 (0xFFFF_FFFF_FFFF_FFFC); beq 0xFE000EE3 -> −4; lui 0x800000B7 -> 0xFFFF_FFFF_8000_0000; jal 0x0080006F -> 8; sh1add (R-type) -> 0.
- Wrap: PC_F=0xFFFF_FFFF_FFFF_FFFC loaded -> PCPlus4_D=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Bundle between fetch/writeback/hazard control and the decode stage.
// Valid_D marks a real instruction in the decode slot; StallD is the only backpressure, FlushD discards the slot.
interface decode_stage_if;
  logic        StallD;
  logic        FlushD;
  logic [63:0] PC_F;
  logic [31:0] Instr_F;
  logic        RegWrite_W;
  logic [4:0]  Rd_W;
  logic [63:0] Result_W;
  logic [63:0] PC_D;
  logic [63:0] PCPlus4_D;
  logic [31:0] Instr_D;
  logic        Valid_D;
  logic [4:0]  Rs1_D;
  logic [4:0]  Rs2_D;
  logic [4:0]  Rd_D;
  logic [63:0] RD1_D;
  logic [63:0] RD2_D;
  logic [63:0] ImmExt_D;

  modport master (
    output StallD, FlushD, PC_F, Instr_F, RegWrite_W, Rd_W, Result_W,
    input  PC_D, PCPlus4_D, Instr_D, Valid_D, Rs1_D, Rs2_D, Rd_D,
           RD1_D, RD2_D, ImmExt_D
  );

  modport slave (
    input  StallD, FlushD, PC_F, Instr_F, RegWrite_W, Rd_W, Result_W,
    output PC_D, PCPlus4_D, Instr_D, Valid_D, Rs1_D, Rs2_D, Rd_D,
           RD1_D, RD2_D, ImmExt_D
  );
endinterface

// File: rtl/decode_stage.sv
// RV64I+Zba decode stage: IF/ID register, 32x64 register file with
// write-through bypass from Writeback, and immediate generator.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave dif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] instr_q;
  logic [63:0] pc_q;
  logic        valid_q;
  logic [63:0] regs [0:31];
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        wb_en;
  logic [63:0] rd1;
  logic [63:0] rd2;
  logic [63:0] imm;

  // IF/ID register: rst > flush > stall > load.
  always_ff @(posedge clk) begin
    if (rst || dif.FlushD) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 64'd0;
      valid_q <= 1'b0;
    end else if (!dif.StallD) begin
      instr_q <= dif.Instr_F;
      pc_q    <= dif.PC_F;
      valid_q <= 1'b1;
    end
  end

  assign wb_en = dif.RegWrite_W && (dif.Rd_W != 5'd0);

  // Entry 0 is cleared on reset and never written; reads of x0 are forced to 0 anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 64'd0;
      end
    end else if (wb_en) begin
      regs[dif.Rd_W] <= dif.Result_W;
    end
  end

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  // Same-cycle Writeback data is forwarded so WB->ID needs no hazard stall.
  always_comb begin
    rd1 = 64'd0;
    rd2 = 64'd0;
    if (rs1 != 5'd0) begin
      rd1 = (wb_en && dif.Rd_W == rs1) ? dif.Result_W : regs[rs1];
    end
    if (rs2 != 5'd0) begin
      rd2 = (wb_en && dif.Rd_W == rs2) ? dif.Result_W : regs[rs2];
    end
  end

  // Shift-immediate funct6 bits are left in place; Execute masks shamt.
  always_comb begin
    imm = 64'd0;
    case (instr_q[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR:
        imm = {{52{instr_q[31]}}, instr_q[31:20]};
      OP_STORE:
        imm = {{52{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OP_BRANCH:
        imm = {{51{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
               instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {{32{instr_q[31]}}, instr_q[31:12], 12'd0};
      OP_JAL:
        imm = {{43{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
               instr_q[30:21], 1'b0};
      default:
        imm = 64'd0;
    endcase
  end

  assign dif.PC_D      = pc_q;
  assign dif.PCPlus4_D = pc_q + 64'd4;
  assign dif.Instr_D   = instr_q;
  assign dif.Valid_D   = valid_q;
  assign dif.Rs1_D     = rs1;
  assign dif.Rs2_D     = rs2;
  assign dif.Rd_D      = instr_q[11:7];
  assign dif.RD1_D     = rd1;
  assign dif.RD2_D     = rd2;
  assign dif.ImmExt_D  = imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, IF/ID stall/flush, register file
// write/bypass, x0 handling, immediate formats and PC+4 wrap.
module tb_decode_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  decode_stage_if dif ();

  decode_stage #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [63:0] pc, input logic [31:0] instr);
    dif.PC_F    = pc;
    dif.Instr_F = instr;
    tick();
  endtask

  logic [31:0] imm_instr [8];
  logic [63:0] imm_exp   [8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    dif.StallD = 1'b0;
    dif.FlushD = 1'b0;
    dif.PC_F = 64'd0;
    dif.Instr_F = 32'd0;
    dif.RegWrite_W = 1'b0;
    dif.Rd_W = 5'd0;
    dif.Result_W = 64'd0;
    tick();
    rst = 1'b0;

    // Write x5, then reset during another write to x5.
    dif.RegWrite_W = 1'b1; dif.Rd_W = 5'd5; dif.Result_W = 64'h55;
    dif.Instr_F = 32'h0050_0093; dif.PC_F = 64'h40;
    tick();
    rst = 1'b1; dif.Result_W = 64'h99;
    tick();
    rst = 1'b0; dif.RegWrite_W = 1'b0;
    chk("rst_instr", {32'd0, dif.Instr_D}, 64'h13);
    chk("rst_valid", {63'd0, dif.Valid_D}, 64'd0);
    chk("rst_pc", dif.PC_D, 64'd0);
    chk("rst_pc4", dif.PCPlus4_D, 64'd4);
    chk("rst_rs1", {59'd0, dif.Rs1_D}, 64'd0);
    chk("rst_rs2", {59'd0, dif.Rs2_D}, 64'd0);
    chk("rst_rd", {59'd0, dif.Rd_D}, 64'd0);
    chk("rst_rd1", dif.RD1_D, 64'd0);
    chk("rst_rd2", dif.RD2_D, 64'd0);
    chk("rst_imm", dif.ImmExt_D, 64'd0);
    load(64'h0, 32'h0002_8093);           // addi x1,x5,0
    chk("x5_after_rst", dif.RD1_D, 64'd0);

    // Load, stall, flush+stall.
    load(64'h100, 32'h0050_0093);          // addi x1,x0,5
    chk("ld_pc", dif.PC_D, 64'h100);
    chk("ld_pc4", dif.PCPlus4_D, 64'h104);
    chk("ld_rd", {59'd0, dif.Rd_D}, 64'd1);
    chk("ld_imm", dif.ImmExt_D, 64'd5);
    chk("ld_valid", {63'd0, dif.Valid_D}, 64'd1);
    dif.StallD = 1'b1;
    load(64'h200, 32'hFFF0_0093);
    chk("stall_pc", dif.PC_D, 64'h100);
    chk("stall_instr", {32'd0, dif.Instr_D}, 64'h0050_0093);
    chk("stall_valid", {63'd0, dif.Valid_D}, 64'd1);
    dif.FlushD = 1'b1;
    tick();
    chk("flush_instr", {32'd0, dif.Instr_D}, 64'h13);
    chk("flush_valid", {63'd0, dif.Valid_D}, 64'd0);
    chk("flush_pc", dif.PC_D, 64'd0);
    dif.FlushD = 1'b0;
    dif.StallD = 1'b0;

    // Write x3 while loading add x4,x3,x0.
    dif.RegWrite_W = 1'b1; dif.Rd_W = 5'd3; dif.Result_W = 64'hDEAD_BEEF_0000_0001;
    load(64'h300, 32'h0001_8233);
    dif.RegWrite_W = 1'b0;
    #1;
    chk("rf_rd1", dif.RD1_D, 64'hDEAD_BEEF_0000_0001);
    chk("rf_rd2", dif.RD2_D, 64'd0);
    chk("rtype_imm", dif.ImmExt_D, 64'd0);
    chk("rf_rs1", {59'd0, dif.Rs1_D}, 64'd3);
    dif.StallD = 1'b1;
    dif.RegWrite_W = 1'b1; dif.Rd_W = 5'd3; dif.Result_W = 64'h7;
    #1;
    chk("bypass_rd1", dif.RD1_D, 64'h7);
    chk("bypass_rd2", dif.RD2_D, 64'd0);
    tick();
    dif.RegWrite_W = 1'b0;
    #1;
    chk("after_wr_rd1", dif.RD1_D, 64'h7);
    chk("after_wr_pc", dif.PC_D, 64'h300);
    dif.StallD = 1'b0;

    // x0 is never written or bypassed.
    load(64'h400, 32'h0000_0093);          // addi x1,x0,0
    dif.RegWrite_W = 1'b1; dif.Rd_W = 5'd0; dif.Result_W = 64'hFF;
    #1;
    chk("x0_bypass", dif.RD1_D, 64'd0);
    dif.StallD = 1'b1;
    tick();
    dif.RegWrite_W = 1'b0;
    #1;
    chk("x0_after", dif.RD1_D, 64'd0);
    dif.StallD = 1'b0;

    // Immediate formats.
    imm_instr[0] = 32'hFFF0_0093; imm_exp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    imm_instr[1] = 32'hFE11_2E23; imm_exp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    imm_instr[2] = 32'hFE00_0EE3; imm_exp[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    imm_instr[3] = 32'h8000_00B7; imm_exp[3] = 64'hFFFF_FFFF_8000_0000;
    imm_instr[4] = 32'h0080_006F; imm_exp[4] = 64'h8;
    imm_instr[5] = 32'h2031_20B3; imm_exp[5] = 64'h0;
    imm_instr[6] = 32'h0000_1097; imm_exp[6] = 64'h1000;
    imm_instr[7] = 32'h7FF0_8067; imm_exp[7] = 64'h7FF;
    for (int i = 0; i < 8; i++) begin
      load(64'h500 + 64'(4 * i), imm_instr[i]);
      chk($sformatf("imm_%0d", i), dif.ImmExt_D, imm_exp[i]);
    end

    // PC+4 wrap.
    load(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013);
    chk("wrap_pc", dif.PC_D, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4", dif.PCPlus4_D, 64'd0);

    // Reset mid-operation beats stall and a same-cycle write.
    load(64'h600, 32'h0001_8233);
    dif.StallD = 1'b1; dif.RegWrite_W = 1'b1; dif.Rd_W = 5'd3; dif.Result_W = 64'h1234;
    rst = 1'b1;
    tick();
    rst = 1'b0; dif.StallD = 1'b0; dif.RegWrite_W = 1'b0;
    chk("midrst_instr", {32'd0, dif.Instr_D}, 64'h13);
    chk("midrst_pc", dif.PC_D, 64'd0);
    load(64'h700, 32'h0001_8233);
    chk("midrst_x3", dif.RD1_D, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
